// File: rtl/axil_pkg.sv
// Shared constants, read-FSM state type and helpers for the AXI-Lite SRAM slave.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Test hooks override the decode; forced error wins over forced success.
  function automatic logic [1:0] resp_sel(input logic force_err, input logic force_ok,
                                          input logic bad);
    if (force_err) return RESP_SLVERR;
    if (force_ok)  return RESP_OKAY;
    return bad ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_sram_slave_if.sv
// AXI-Lite bus bundle between the sort engine master and the SRAM slave.
interface axil_sram_slave_if #(
  parameter int ADDR_WDTH = 10,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 2
);
  logic                   ar_valid;
  logic                   ar_ready;
  logic [ADDR_WDTH-1:0]   ar_address;
  logic                   r_valid;
  logic                   r_ready;
  logic [DATA_WDTH-1:0]   r_data;
  logic [RESP_WDTH-1:0]   r_resp;
  logic                   aw_valid;
  logic                   aw_ready;
  logic [ADDR_WDTH-1:0]   aw_address;
  logic                   w_valid;
  logic                   w_ready;
  logic [DATA_WDTH-1:0]   w_data;
  logic [DATA_WDTH/8-1:0] w_strb;
  logic                   b_valid;
  logic                   b_ready;
  logic [RESP_WDTH-1:0]   b_resp;

  modport slave (
    input  ar_valid, ar_address, r_ready, aw_valid, aw_address,
           w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport master (
    output ar_valid, ar_address, r_ready, aw_valid, aw_address,
           w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/axil_sram_array.sv
// DEPTH x DATA_WDTH storage split into byte lanes: byte-enable write, registered read.
module axil_sram_array #(
  parameter int DATA_WDTH = 32,
  parameter int DEPTH     = 64,
  parameter int IDX_W     = 6
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [DATA_WDTH-1:0]   wr_data,
  input  logic [DATA_WDTH/8-1:0] wr_strb,
  input  logic                   rd_en,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [DATA_WDTH-1:0]   rd_data
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WDTH / 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_reg;

      // Read-before-write: a same-cycle read of the written word sees old data.
      always_ff @(posedge clk) begin
        if (wr_en && wr_strb[gi]) begin
          lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
        end
        if (rd_en) begin
          lane_rd_reg <= lane_mem[rd_idx];
        end
      end

      assign rd_data[gi*8 +: 8] = lane_rd_reg;
    end
  endgenerate

endmodule

// File: rtl/axil_sram_slave.sv
// AXI-Lite slave memory with independent AW/W capture, byte strobes,
// address-decode errors and a configurable read latency.
module axil_sram_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WDTH  = 10,
  parameter int DATA_WDTH  = 32,
  parameter int DEPTH      = 64,
  parameter int RD_LATENCY = 1,
  parameter int RESP_WDTH  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic always_success,
  input  logic always_error,
  axil_sram_slave_if.slave bus
);

  localparam int BYTES = DATA_WDTH / 8;
  localparam int OFF_W = clog2(BYTES);
  localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [ADDR_WDTH-1:0] OFF_MASK = ADDR_WDTH'((1 << OFF_W) - 1);
  localparam logic [1:0] LAT_LAST = 2'((RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0);

  function automatic logic addr_bad(input logic [ADDR_WDTH-1:0] addr);
    logic [ADDR_WDTH-1:0] word;
    word = addr >> OFF_W;
    return ((addr & OFF_MASK) != '0) || (int'(word) >= DEPTH);
  endfunction

  // Readies stay low until the first clock after reset release.
  logic alive_reg;

  logic                 aw_held_reg;
  logic [ADDR_WDTH-1:0] aw_addr_reg;
  logic                 w_held_reg;
  logic [DATA_WDTH-1:0] w_data_reg;
  logic [BYTES-1:0]     w_strb_reg;
  logic                 b_valid_reg;
  logic [RESP_WDTH-1:0] b_resp_reg;

  rd_state_t            state_reg, state_next;
  logic [1:0]           cnt_reg, cnt_next;
  logic                 rd_bad_reg;
  logic [RESP_WDTH-1:0] rd_resp_reg;

  logic                 aw_hs, w_hs, ar_hs, commit, wr_bad, wr_en;
  logic [DATA_WDTH-1:0] rd_data;

  assign aw_hs  = bus.aw_valid && bus.aw_ready;
  assign w_hs   = bus.w_valid && bus.w_ready;
  assign ar_hs  = bus.ar_valid && bus.ar_ready;
  assign commit = aw_held_reg && w_held_reg && !b_valid_reg;
  assign wr_bad = addr_bad(aw_addr_reg);
  assign wr_en  = commit && !wr_bad && !always_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_reg <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_reg <= 1'b0;
      aw_addr_reg <= '0;
      w_held_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      b_valid_reg <= 1'b0;
      b_resp_reg  <= RESP_WDTH'(RESP_OKAY);
    end else begin
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        b_valid_reg <= 1'b1;
        b_resp_reg  <= RESP_WDTH'(resp_sel(always_error, always_success, wr_bad));
      end else if (b_valid_reg && bus.b_ready) begin
        b_valid_reg <= 1'b0;
      end
      // Ready is low while a hold is full, so capture never collides with commit.
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        aw_addr_reg <= bus.aw_address;
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        w_data_reg <= bus.w_data;
        w_strb_reg <= bus.w_strb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= R_IDLE;
      cnt_reg     <= '0;
      rd_bad_reg  <= 1'b0;
      rd_resp_reg <= RESP_WDTH'(RESP_OKAY);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (ar_hs) begin
        rd_bad_reg  <= addr_bad(bus.ar_address);
        rd_resp_reg <= RESP_WDTH'(resp_sel(always_error, always_success,
                                           addr_bad(bus.ar_address)));
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      R_IDLE: begin
        if (ar_hs) begin
          cnt_next   = '0;
          state_next = (RD_LATENCY > 1) ? R_WAIT : R_RESP;
        end
      end
      R_WAIT: begin
        if (cnt_reg == LAT_LAST) begin
          state_next = R_RESP;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      R_RESP: begin
        if (bus.r_ready) begin
          state_next = R_IDLE;
        end
      end
      default: state_next = R_IDLE;
    endcase
  end

  // The array output register only reloads on an AR handshake, so r_data holds.
  axil_sram_array #(
    .DATA_WDTH (DATA_WDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (IDX_W'(aw_addr_reg >> OFF_W)),
    .wr_data (w_data_reg),
    .wr_strb (w_strb_reg),
    .rd_en   (ar_hs),
    .rd_idx  (IDX_W'(bus.ar_address >> OFF_W)),
    .rd_data (rd_data)
  );

  assign bus.ar_ready = alive_reg && (state_reg == R_IDLE);
  assign bus.aw_ready = alive_reg && !aw_held_reg;
  assign bus.w_ready  = alive_reg && !w_held_reg;
  assign bus.r_valid  = (state_reg == R_RESP);
  assign bus.r_data   = ((state_reg == R_RESP) && !rd_bad_reg) ? rd_data : '0;
  assign bus.r_resp   = rd_resp_reg;
  assign bus.b_valid  = b_valid_reg;
  assign bus.b_resp   = b_resp_reg;

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed bench for axil_sram_slave: cycle-exact write/read latency, strobes,
// decode errors, B back-pressure, test hooks and mid-operation reset.
module tb_axil_sram_slave;
  import axil_pkg::*;

  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic always_success = 1'b0;
  logic always_error   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  axil_sram_slave_if #(.ADDR_WDTH(10), .DATA_WDTH(32), .RESP_WDTH(2)) bus ();

  axil_sram_slave #(
    .ADDR_WDTH  (10),
    .DATA_WDTH  (32),
    .DEPTH      (64),
    .RD_LATENCY (RD_LAT),
    .RESP_WDTH  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .always_success (always_success),
    .always_error   (always_error),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_both(input string tag, input logic [9:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
    chk({tag, "_awrdy"}, 32'(bus.aw_ready), 32'd1);
    chk({tag, "_wrdy"}, 32'(bus.w_ready), 32'd1);
    bus.aw_valid = 1'b1; bus.aw_address = addr;
    bus.w_valid = 1'b1;  bus.w_data = data; bus.w_strb = strb;
    bus.b_ready = 1'b1;
    tick;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk({tag, "_bvalid_n1"}, 32'(bus.b_valid), 32'd0);
    tick;
    chk({tag, "_bvalid_n2"}, 32'(bus.b_valid), 32'd1);
    chk({tag, "_bresp"}, 32'(bus.b_resp), 32'(exp_resp));
    tick;
    chk({tag, "_bdone"}, 32'(bus.b_valid), 32'd0);
    $display("write %s addr=%h data=%h strb=%h resp=%0d", tag, addr, data, strb, exp_resp);
  endtask

  task automatic do_read(input string tag, input logic [9:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    chk({tag, "_arrdy"}, 32'(bus.ar_ready), 32'd1);
    bus.ar_valid = 1'b1; bus.ar_address = addr; bus.r_ready = 1'b0;
    tick;
    bus.ar_valid = 1'b0;
    for (int k = 1; k < RD_LAT; k++) begin
      chk({tag, "_rvalid_early"}, 32'(bus.r_valid), 32'd0);
      tick;
    end
    chk({tag, "_rvalid"}, 32'(bus.r_valid), 32'd1);
    chk({tag, "_rdata"}, bus.r_data, exp_data);
    chk({tag, "_rresp"}, 32'(bus.r_resp), 32'(exp_resp));
    tick;
    chk({tag, "_rdata_hold"}, bus.r_data, exp_data);
    chk({tag, "_rvalid_hold"}, 32'(bus.r_valid), 32'd1);
    bus.r_ready = 1'b1;
    tick;
    bus.r_ready = 1'b0;
    chk({tag, "_rdone"}, 32'(bus.r_valid), 32'd0);
    $display("read  %s addr=%h data=%h resp=%0d", tag, addr, exp_data, exp_resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ar_valid = 0; bus.ar_address = '0; bus.r_ready = 0;
    bus.aw_valid = 0; bus.aw_address = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.b_ready = 1;

    // Reset state
    tick; tick;
    chk("rst_arrdy", 32'(bus.ar_ready), 32'd0);
    chk("rst_awrdy", 32'(bus.aw_ready), 32'd0);
    chk("rst_wrdy", 32'(bus.w_ready), 32'd0);
    chk("rst_rvalid", 32'(bus.r_valid), 32'd0);
    chk("rst_bvalid", 32'(bus.b_valid), 32'd0);
    chk("rst_rdata", bus.r_data, 32'd0);
    chk("rst_rresp", 32'(bus.r_resp), 32'(RESP_OKAY));
    chk("rst_bresp", 32'(bus.b_resp), 32'(RESP_OKAY));
    rst = 1'b0;
    tick;
    chk("post_rst_arrdy", 32'(bus.ar_ready), 32'd1);
    chk("post_rst_awrdy", 32'(bus.aw_ready), 32'd1);
    chk("post_rst_wrdy", 32'(bus.w_ready), 32'd1);
    $display("reset released");

    // 1: simultaneous AW/W, then read back
    write_both("t1", 10'h010, 32'hDEADBEEF, 4'hF, RESP_OKAY);
    do_read("t1", 10'h010, 32'hDEADBEEF, RESP_OKAY);

    // 2: W three cycles ahead of AW, then a single-byte update
    bus.w_valid = 1'b1; bus.w_data = 32'hDEADBEEF; bus.w_strb = 4'hF;
    tick;
    bus.w_valid = 1'b0;
    chk("t2_wrdy_held", 32'(bus.w_ready), 32'd0);
    chk("t2_bvalid_w0", 32'(bus.b_valid), 32'd0);
    tick;
    chk("t2_bvalid_w1", 32'(bus.b_valid), 32'd0);
    tick;
    chk("t2_bvalid_w2", 32'(bus.b_valid), 32'd0);
    bus.aw_valid = 1'b1; bus.aw_address = 10'h020;
    tick;
    bus.aw_valid = 1'b0;
    chk("t2_bvalid_aw1", 32'(bus.b_valid), 32'd0);
    tick;
    chk("t2_bvalid_aw2", 32'(bus.b_valid), 32'd1);
    chk("t2_bresp", 32'(bus.b_resp), 32'(RESP_OKAY));
    tick;
    chk("t2_bdone", 32'(bus.b_valid), 32'd0);
    $display("write t2_early addr=020 data=deadbeef strb=f resp=0");
    write_both("t2_byte", 10'h020, 32'h000000AA, 4'h1, RESP_OKAY);
    do_read("t2", 10'h020, 32'hDEADBEAA, RESP_OKAY);

    // 3: out-of-range and misaligned decode
    do_read("t3_oor", 10'h100, 32'd0, RESP_SLVERR);
    do_read("t3_mis", 10'h013, 32'd0, RESP_SLVERR);
    write_both("t3_w0", 10'h000, 32'h11223344, 4'hF, RESP_OKAY);
    write_both("t3_wbad", 10'h100, 32'hFFFFFFFF, 4'hF, RESP_SLVERR);
    do_read("t3_w0", 10'h000, 32'h11223344, RESP_OKAY);

    // 4: B back-pressure across two queued writes
    bus.b_ready = 1'b0;
    bus.aw_valid = 1'b1; bus.aw_address = 10'h030;
    bus.w_valid = 1'b1;  bus.w_data = 32'hA5A5A5A5; bus.w_strb = 4'hF;
    tick;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk("t4_bvalid_n1", 32'(bus.b_valid), 32'd0);
    tick;
    chk("t4_bvalid_a", 32'(bus.b_valid), 32'd1);
    chk("t4_awrdy_free", 32'(bus.aw_ready), 32'd1);
    bus.aw_valid = 1'b1; bus.aw_address = 10'h103;
    bus.w_valid = 1'b1;  bus.w_data = 32'h5A5A5A5A; bus.w_strb = 4'hF;
    tick;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t4_bvalid_stall", 32'(bus.b_valid), 32'd1);
      chk("t4_bresp_stall", 32'(bus.b_resp), 32'(RESP_OKAY));
      chk("t4_awrdy_stall", 32'(bus.aw_ready), 32'd0);
      tick;
    end
    bus.b_ready = 1'b1;
    tick;
    chk("t4_bgap", 32'(bus.b_valid), 32'd0);
    chk("t4_awrdy_gap", 32'(bus.aw_ready), 32'd0);
    tick;
    chk("t4_bvalid_b", 32'(bus.b_valid), 32'd1);
    chk("t4_bresp_b", 32'(bus.b_resp), 32'(RESP_SLVERR));
    chk("t4_awrdy_after", 32'(bus.aw_ready), 32'd1);
    tick;
    chk("t4_bdone", 32'(bus.b_valid), 32'd0);
    $display("write t4 two queued writes resp=0 then resp=2");
    do_read("t4", 10'h030, 32'hA5A5A5A5, RESP_OKAY);

    // 5: test hooks
    always_error = 1'b1;
    write_both("t5_err", 10'h010, 32'h12345678, 4'hF, RESP_SLVERR);
    always_success = 1'b1;
    write_both("t5_both", 10'h010, 32'h12345678, 4'hF, RESP_SLVERR);
    always_error = 1'b0;
    do_read("t5_succ_oor", 10'h100, 32'd0, RESP_OKAY);
    always_success = 1'b0;
    do_read("t5_unchanged", 10'h010, 32'hDEADBEEF, RESP_OKAY);

    // 6: reset with a pending R and a held AW
    bus.ar_valid = 1'b1; bus.ar_address = 10'h010; bus.r_ready = 1'b0;
    bus.aw_valid = 1'b1; bus.aw_address = 10'h040;
    tick;
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
    chk("t6_aw_held", 32'(bus.aw_ready), 32'd0);
    tick;
    chk("t6_rvalid_pre", 32'(bus.r_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rvalid_rst", 32'(bus.r_valid), 32'd0);
    chk("t6_bvalid_rst", 32'(bus.b_valid), 32'd0);
    chk("t6_arrdy_rst", 32'(bus.ar_ready), 32'd0);
    chk("t6_awrdy_rst", 32'(bus.aw_ready), 32'd0);
    tick;
    rst = 1'b0;
    tick;
    chk("t6_arrdy_rel", 32'(bus.ar_ready), 32'd1);
    chk("t6_awrdy_rel", 32'(bus.aw_ready), 32'd1);
    chk("t6_wrdy_rel", 32'(bus.w_ready), 32'd1);
    chk("t6_rvalid_rel", 32'(bus.r_valid), 32'd0);
    $display("reset mid-operation released");
    bus.w_valid = 1'b1; bus.w_data = 32'h0BADF00D; bus.w_strb = 4'hF;
    tick;
    bus.w_valid = 1'b0;
    tick;
    chk("t6_no_stale_b", 32'(bus.b_valid), 32'd0);
    chk("t6_no_stale_r", 32'(bus.r_valid), 32'd0);
    bus.aw_valid = 1'b1; bus.aw_address = 10'h044;
    tick;
    bus.aw_valid = 1'b0;
    chk("t6_bvalid_n1", 32'(bus.b_valid), 32'd0);
    tick;
    chk("t6_bvalid_n2", 32'(bus.b_valid), 32'd1);
    chk("t6_bresp", 32'(bus.b_resp), 32'(RESP_OKAY));
    tick;
    chk("t6_bdone", 32'(bus.b_valid), 32'd0);
    $display("write t6 addr=044 data=0badf00d strb=f resp=0");
    do_read("t6_new", 10'h044, 32'h0BADF00D, RESP_OKAY);
    do_read("t6_kept", 10'h010, 32'hDEADBEEF, RESP_OKAY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
